// File: rtl/afe_spi_stream_capture_if.sv
// Pin/bus bundle between the AFE capture block, the AFE pins and the
// data_buffer streaming read port. The capture block uses the slave view,
// whoever drives the AFE inputs and the read address uses the master view.
`timescale 1ns/1ps
interface afe_spi_stream_capture_if;
    logic        in_enable;
    logic        in_adc_rdy;
    logic        spi_somi;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_ste_n;
    logic [2:0]  in_addr;
    logic [23:0] out_strm_data;
    logic        out_strm_dn;
    logic        out_busy;
    logic        out_overrun;
    logic [2:0]  dbg_state;

    modport master (
        output in_enable, in_adc_rdy, spi_somi, in_addr,
        input  spi_sclk, spi_mosi, spi_ste_n, out_strm_data,
               out_strm_dn, out_busy, out_overrun, dbg_state
    );

    modport slave (
        input  in_enable, in_adc_rdy, spi_somi, in_addr,
        output spi_sclk, spi_mosi, spi_ste_n, out_strm_data,
               out_strm_dn, out_busy, out_overrun, dbg_state
    );
endinterface

// File: rtl/afe_spi_stream_capture.sv
// SPI master that bursts the AFE result/diag registers into a committed
// 8-slot x 24-bit bank on every ADC_RDY rising edge. The bank only changes in
// a single COMMIT cycle, so the streaming reader sees whole sets only.
// Read port: out_strm_data(t+1) = bank[in_addr(t)], slot 7 is always zero.
`timescale 1ns/1ps
module afe_spi_stream_capture #(
    parameter int CLK_DIV = 4,   // clk cycles per SCLK half period, 2..255
    parameter int STE_GAP = 8    // clk cycles ste_n stays high between frames, >= 2
) (
    input logic                     clk,
    input logic                     in_reset_n,
    afe_spi_stream_capture_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        GAP    = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    // One of the STE_GAP high cycles is spent in LOAD, hence the -2.
    localparam logic [15:0] GAP_LAST = 16'(STE_GAP - 2);

    state_t      state;
    logic [2:0]  frame_idx;
    logic [7:0]  div_cnt;
    logic [6:0]  half_cnt;
    logic [15:0] gap_cnt;
    logic [31:0] tx_sreg;
    logic [23:0] rx_sreg;
    logic        sclk_q;
    logic        ste_n_q;
    logic        busy_q;
    logic        dn_q;
    logic        overrun_q;
    logic [23:0] stage [0:6];
    logic [23:0] bank  [0:6];
    logic [23:0] strm_data_q;
    logic [23:0] rd_val;
    logic [31:0] load_word;

    logic rdy_meta;
    logic rdy_sync;
    logic rdy_prev;
    logic rdy_evt;

    // Two-flop synchroniser for ADC_RDY plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
            rdy_prev <= 1'b0;
        end else begin
            rdy_meta <= bus.in_adc_rdy;
            rdy_sync <= rdy_meta;
            rdy_prev <= rdy_sync;
        end
    end

    assign rdy_evt = rdy_sync & ~rdy_prev;

    // Frame word for the current frame: CONTROL0 write first, then reads.
    always_comb begin
        load_word = 32'h0000_0001;
        if (frame_idx != 3'd0) begin
            load_word = {8'h29 + {5'd0, frame_idx}, 24'h00_0000};
        end
    end

    // Burst sequencer: frame loading, SCLK generation, shifting, gaps, commit.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state     <= IDLE;
            frame_idx <= 3'd0;
            div_cnt   <= 8'd0;
            half_cnt  <= 7'd0;
            gap_cnt   <= 16'd0;
            tx_sreg   <= 32'd0;
            rx_sreg   <= 24'd0;
            sclk_q    <= 1'b0;
            ste_n_q   <= 1'b1;
            busy_q    <= 1'b0;
            dn_q      <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                stage[i] <= 24'd0;
                bank[i]  <= 24'd0;
            end
        end else begin
            dn_q <= 1'b0;
            // A ready edge that cannot be serviced is dropped and remembered.
            if (rdy_evt && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rdy_evt && bus.in_enable) begin
                        busy_q    <= 1'b1;
                        frame_idx <= 3'd0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    tx_sreg  <= load_word;
                    ste_n_q  <= 1'b0;
                    div_cnt  <= 8'd0;
                    half_cnt <= 7'd0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= 8'd0;
                        half_cnt <= half_cnt + 7'd1;
                        if (half_cnt == 7'd64) begin
                            // Trailing half period done: close the frame.
                            ste_n_q <= 1'b1;
                            sclk_q  <= 1'b0;
                            tx_sreg <= 32'd0;
                            for (int i = 0; i < 7; i++) begin
                                if (frame_idx == 3'(i + 1)) begin
                                    stage[i] <= rx_sreg;
                                end
                            end
                            gap_cnt <= 16'd0;
                            state   <= GAP;
                        end else if (!half_cnt[0]) begin
                            sclk_q  <= 1'b1;
                            rx_sreg <= {rx_sreg[22:0], bus.spi_somi};
                        end else begin
                            sclk_q  <= 1'b0;
                            tx_sreg <= {tx_sreg[30:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (frame_idx == 3'd7) begin
                            state <= COMMIT;
                        end else begin
                            frame_idx <= frame_idx + 3'd1;
                            state     <= LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < 7; i++) begin
                        bank[i] <= stage[i];
                    end
                    busy_q <= 1'b0;
                    dn_q   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slot select for the read port; slot 7 has no backing register.
    always_comb begin
        rd_val = 24'd0;
        for (int i = 0; i < 7; i++) begin
            if (bus.in_addr == 3'(i)) begin
                rd_val = bank[i];
            end
        end
    end

    // Registered streaming read, one cycle latency.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            strm_data_q <= 24'd0;
        end else begin
            strm_data_q <= rd_val;
        end
    end

    assign bus.spi_sclk      = sclk_q;
    assign bus.spi_mosi      = tx_sreg[31];
    assign bus.spi_ste_n     = ste_n_q;
    assign bus.out_strm_data = strm_data_q;
    assign bus.out_strm_dn   = dn_q;
    assign bus.out_busy      = busy_q;
    assign bus.out_overrun   = overrun_q;
    assign bus.dbg_state     = state;

endmodule

// File: doc/afe_spi_stream_capture.md
Name: afe_spi_stream_capture

Overview:
- SPI master that bursts the AFE result/diag registers into a committed 8-slot x 24-bit register bank on each AFE ADC_RDY.
- Feeds data_buffer's streaming read port: slot index in, registered data out with 1-cycle latency.
- Raises a one-cycle sample-set-done strobe once a complete, consistent set has been committed.
- Sits between the AFE pins and data_buffer.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); legal range 2..255.
- STE_GAP, 8: clk cycles spi_ste_n is held high between frames; minimum 2.

Ports:
- clk  input  1  system clock
- in_reset_n  input  1  asynchronous active-low reset
- in_enable  input  1  high = service ADC_RDY; low = ignore new ADC_RDY edges
- in_adc_rdy  input  1  AFE ADC_RDY, asynchronous to clk
- spi_somi  input  1  AFE serial data out
- spi_sclk  output  1  SPI clock, idle low (mode 0)
- spi_mosi  output  1  SPI data to AFE
- spi_ste_n  output  1  AFE chip select, active low
- in_addr  input  3  bank read slot
- out_strm_data  output  24  registered bank[in_addr]
- out_strm_dn  output  1  one-cycle strobe: new set committed
- out_busy  output  1  burst in progress
- out_overrun  output  1  sticky: ADC_RDY edge arrived while busy

Behaviour:
- Reset (async assert, sync release). All outputs go to 0, except spi_ste_n = 1. All bank slots, staging registers, counters and FSM are cleared; FSM enters IDLE.
- ADC_RDY synchronisation. in_adc_rdy passes through a 2-FF synchroniser. Rising-edge detect on the synchronised signal produces rdy_evt.
- Burst start. rdy_evt with in_enable=1 in IDLE starts a burst. rdy_evt while busy sets out_overrun; the current burst is not disturbed and the event is dropped. out_overrun clears only on reset.
- Frame format. Each frame is 32 SCLK periods with spi_ste_n low for the whole frame. The first 8 bits are the register address and the next 24 are data, both MSB first.
  - MOSI changes on the SCLK falling edge (first bit driven before the first rise).
  - SOMI is sampled on the SCLK rising edge.
  - spi_ste_n falls CLK_DIV clks before the first SCLK rise and rises CLK_DIV clks after the last SCLK fall.
- Burst sequence, 8 frames:
  - Frame 0: write 0x00 / 0x000001 (CONTROL0 SPI_READ=1).
  - Frames 1..7: reads of AFE addresses 0x2A, 0x2B, 0x2C, 0x2D, 0x2E, 0x2F, 0x30. During read frames MOSI carries 0 in the data bits.
  - The 24 data bits of each read frame land in staging slots 0..6 respectively: LED2, ALED2, LED1, ALED1, LED2-ALED2, LED1-ALED1, DIAG.
- FSM states:
  - IDLE: on rdy_evt with in_enable=1, go to LOAD.
  - LOAD: load the shift register for frame_idx; assert ste_n low.
  - SHIFT: run the 32-bit counter; at the end, store into staging if it was a read frame.
  - GAP: hold ste_n high for STE_GAP clks.
  - COMMIT: after frame 7's gap, copy all 7 staging slots into the bank in a single clk, then return to IDLE.
- out_strm_dn is high exactly one clk, on the clk after COMMIT. Bank contents are therefore valid when the strobe is seen.
- out_busy is high from the clk after the start event through the COMMIT clk inclusive.
- Read port. out_strm_data(t+1) = bank[in_addr(t)]. Slot 7 always reads 0x000000. The bank never changes except in COMMIT, so a reader sees either the old set or the new set, never a mix.
- in_enable dropping mid-burst does not abort the burst. It only blocks subsequent starts.
- Reset mid-burst: all state returns to reset values at once, including spi_ste_n=1 and spi_sclk=0. The bank is cleared and no out_strm_dn is issued.
- Burst length: 8*(64*CLK_DIV + 2*CLK_DIV + STE_GAP) + a few clks of fixed overhead. At the defaults this is about 2200 clks.

Test Plan:
- Reset: assert in_reset_n=0 mid-idle → spi_ste_n=1, spi_sclk=0, out_strm_dn=0, out_busy=0, out_strm_data=0 for in_addr=0..7.
- Single burst: AFE model returns 0x2A→0x123456, 0x2B→0x00ABCD, 0x2C→0x3FFFFF, 0x2D→0x000001, 0x2E→0x222222, 0x2F→0x333333, 0x30→0x000000; pulse in_adc_rdy.
  - MOSI frame 0 = 0x00000001; read frames carry 0x2A..0x30 then zero data.
  - out_strm_dn high for exactly 1 clk; then in_addr 0..6 return the values above 1 clk later, and slot 7 returns 0.
- Atomicity: hold in_addr=0 throughout a second burst whose LED2 value is 0x0F0F0F → out_strm_data stays 0x123456 until the clk after COMMIT, then reads 0x0F0F0F.
- Overrun: second in_adc_rdy edge issued during frame 3 → out_overrun=1, only one out_strm_dn pulse; out_overrun stays 1 after the next clean burst.
- Enable gating: in_enable=0 with in_adc_rdy pulses → spi_ste_n stays 1, no strobe.
  - Dropping in_enable during frame 2 → that burst still completes and commits.
- Reset mid-burst: in_reset_n low during frame 5 → all outputs at reset values asynchronously, bank reads 0, no strobe.
  - The next in_adc_rdy after release produces a normal full burst.
